aes_core_arbiter: RTL and testbench

Shares one aes_encrypt core between N_REQ independent requesters.
- Grants requesters round-robin and captures the winner's plaintext.
- Issues a single load pulse to the core, then waits for the core's valid pulse.
- Returns the ciphertext tagged with the requester index over a valid/ready response channel.
- Sits between board-level sources (button/LED test logic, UART loaders) and the single encryption core.
- The key is fixed at core level and is not handled here.

---
 rtl/aes_core_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing a single aes_encrypt core among N_REQ requesters.
// One transaction is in flight at a time; a core timeout is reported as rsp_err with a zero ciphertext.
module aes_core_arbiter #(
   parameter int  N_REQ   = 4,
   parameter int  TIMEOUT = 64,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*128-1:0] req_pt,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [127:0]         rsp_ct,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_err,
   output logic                 core_load,
   output logic [127:0]         core_pt,
   input  logic [127:0]         core_ct,
   input  logic                 core_valid,
   output logic                 busy
);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d, rsp_id_q, rsp_id_d;
   logic [ID_W-1:0]    grant_idx_s, scan_idx_s;
   logic               grant_found_s;
   int                 scan_s;
   logic [TMR_W-1:0]   timer_q, timer_d, timer_inc_s;
   logic [127:0]       core_pt_q, core_pt_d, rsp_ct_q, rsp_ct_d;
   logic [127:0]       pt_arr_s [N_REQ];
   logic               core_load_q, core_load_d, rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d, busy_q, busy_d;

   // Unpack the flat plaintext bus into per-requester words
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         pt_arr_s[k] = req_pt[k*128 +: 128];
      end
   end

   // Round-robin search: first valid requester at or above the pointer, wrapping
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      scan_s        = 0;
      scan_idx_s    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_s = int'(rr_q) + k;
         if (scan_s >= N_REQ) begin
            scan_s = scan_s - N_REQ;
         end else begin
            scan_s = scan_s;
         end
         scan_idx_s = ID_W'(scan_s);
         if (!grant_found_s && req_valid[scan_idx_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = scan_idx_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Grant is offered only while idle
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_found_s) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      rsp_id_d    = rsp_id_q;
      timer_d     = timer_q;
      core_pt_d   = core_pt_q;
      rsp_ct_d    = rsp_ct_q;
      rsp_err_d   = rsp_err_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      core_load_d = 1'b0;
      timer_inc_s = timer_q + TMR_W'(1);
      case (state_q)
         S_IDLE: begin
            if (grant_found_s) begin
               core_pt_d   = pt_arr_s[grant_idx_s];
               rsp_id_d    = grant_idx_s;
               if (grant_idx_s == ID_W'(N_REQ - 1)) begin
                  rr_d = '0;
               end else begin
                  rr_d = grant_idx_s + ID_W'(1);
               end
               core_load_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle still beats the timeout
            if (core_valid) begin
               rsp_ct_d    = core_ct;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (timer_inc_s == TMR_W'(TIMEOUT - 1)) begin
               rsp_ct_d    = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               timer_d = timer_inc_s;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         rsp_id_q    <= '0;
         timer_q     <= '0;
         core_pt_q   <= '0;
         rsp_ct_q    <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         core_load_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         rsp_id_q    <= rsp_id_d;
         timer_q     <= timer_d;
         core_pt_q   <= core_pt_d;
         rsp_ct_q    <= rsp_ct_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         core_load_q <= core_load_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_ct    = rsp_ct_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;
   assign core_load = core_load_q;
   assign core_pt   = core_pt_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: directed vector table, hand sequences and
// randomized transactions compared against a transaction-level round-robin model.
module tb_aes_core_arbiter;
   localparam int N  = 4;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req_valid, req_ready;
   logic [N*128-1:0] req_pt;
   logic         rsp_valid, rsp_ready, rsp_err, core_load, core_valid, busy;
   logic [127:0] rsp_ct, core_pt, core_ct;
   logic [1:0]   rsp_id;

   int checks = 0, failures = 0;
   int rr_m = 0;
   int core_lat = 0, core_cnt = 0, stray_req = 0, stray_done = 0;
   logic [127:0] core_buf, last_ct;
   logic [127:0] pt_arr [N];

   typedef struct {
      logic [3:0] mask;
      int         lat;
      int         stall;
      int         exp_id;
      logic       exp_err;
   } vec_t;
   vec_t tbl [13];

   aes_core_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_pt(req_pt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_id(rsp_id),
      .rsp_err(rsp_err), .core_load(core_load), .core_pt(core_pt), .core_ct(core_ct),
      .core_valid(core_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] enc(input logic [127:0] p);
      logic [127:0] x;
      x = p ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      return {x[100:0], x[127:101]} + 128'd12345;
   endfunction

   // Round-robin reference: first asserted requester at or after the model pointer
   function automatic int predict(input logic [3:0] m);
      for (int k = 0; k < N; k++) begin
         if (m[(rr_m + k) % N]) return (rr_m + k) % N;
      end
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fill_pts();
      for (int i = 0; i < N; i++) pt_arr[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Behavioural aes core: result L cycles after load (L=0 never answers), plus stray pulses on request
   initial begin
      core_valid = 1'b0;
      core_ct    = '0;
      core_buf   = '0;
      forever begin
         @(negedge clk);
         core_valid = 1'b0;
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               core_valid = 1'b1;
               core_ct    = core_buf;
            end
         end
         if (core_load && core_lat > 0) begin
            core_cnt = core_lat;
            core_buf = enc(core_pt);
         end
         if (stray_done != stray_req) begin
            stray_done = stray_req;
            core_valid = 1'b1;
            core_ct    = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   task automatic run_txn(input logic [3:0] mask, input int lat, input int stall,
                          input int exp_id, input logic exp_err);
      int n;
      logic bad;
      logic [127:0] pt, exp_ct;
      core_lat = lat;
      for (int i = 0; i < N; i++) req_pt[i*128 +: 128] = pt_arr[i];
      req_valid = mask;
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 5) begin
         @(negedge clk); #1; n++;
      end
      chk("grant_delay", 128'(n), 128'(0));
      chk("req_ready", 128'(req_ready), 128'(4'b0001 << exp_id));
      pt     = pt_arr[exp_id];
      exp_ct = exp_err ? 128'd0 : enc(pt);
      @(negedge clk); #1;
      req_valid = '0;
      chk("core_load", 128'(core_load), 128'(1));
      chk("core_pt", core_pt, pt);
      rr_m = (exp_id + 1) % N;
      @(negedge clk); #1;
      n = 2; bad = 1'b0;
      while (!rsp_valid && n < TO + 20) begin
         if (req_ready != 4'b0 || !busy || core_load) bad = 1'b1;
         @(negedge clk); #1; n++;
      end
      chk("wait_quiet", 128'(bad), 128'(0));
      chk("latency", 128'(n), 128'(exp_err ? TO + 1 : lat + 2));
      chk("rsp_id", 128'(rsp_id), 128'(exp_id));
      chk("rsp_err", 128'(rsp_err), 128'(exp_err));
      chk("rsp_ct", rsp_ct, exp_ct);
      chk("core_pt_hold", core_pt, pt);
      req_valid = 4'hF;
      #1;
      bad = 1'b0;
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) begin
            @(negedge clk); #1;
         end
         if (s == 1 && stall >= 4) stray_req++;
         if (!rsp_valid || rsp_ct !== exp_ct || rsp_id !== 2'(exp_id) || rsp_err !== exp_err
             || req_ready != 4'b0 || !busy) bad = 1'b1;
      end
      chk("resp_hold", 128'(bad), 128'(0));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("rsp_drop", 128'({rsp_valid, busy}), 128'(0));
      chk("regrant", 128'(req_ready), 128'(4'b0001 << rr_m));
      req_valid = '0;
      last_ct = exp_ct;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int eid, lat, r;
      logic [3:0] m;
      logic bad;
      tbl[0]  = '{4'b0001, 10, 0, 0, 1'b0};
      for (int i = 1; i <= 8; i++) tbl[i] = '{4'b1111, 3, 0, i % N, 1'b0};
      tbl[9]  = '{4'b1111, 5, 20, 1, 1'b0};
      tbl[10] = '{4'b0100, 0, 0, 2, 1'b1};
      tbl[11] = '{4'b1010, TO - 1, 0, 3, 1'b0};
      tbl[12] = '{4'b1010, TO, 4, 1, 1'b1};

      rst_n = 1'b0; req_valid = '0; req_pt = '0; rsp_ready = 1'b0; last_ct = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outs", 128'({req_ready, core_load, rsp_valid, rsp_err, rsp_id, busy}), 128'(0));
      chk("reset_ct", rsp_ct, 128'd0);
      chk("reset_pt", core_pt, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 13; v++) begin
         fill_pts();
         if (v == 0) pt_arr[0] = 128'h05060708090a0b0c0d0e0f1011121314;
         run_txn(tbl[v].mask, tbl[v].lat, tbl[v].stall, tbl[v].exp_id, tbl[v].exp_err);
      end

      // Spurious core pulse while idle must leave everything untouched
      stray_req++;
      repeat (3) @(negedge clk);
      #1;
      chk("idle_stray", 128'({busy, rsp_valid, core_load}), 128'(0));
      chk("idle_stray_ct", rsp_ct, last_ct);

      // Reset in the middle of a wait aborts the transaction
      core_lat = 20;
      req_valid = 4'hF;
      #1;
      chk("pre_rst_grant", 128'(req_ready), 128'(4'b0001 << rr_m));
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      #1;
      chk("pre_rst_busy", 128'(busy), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", 128'({req_ready, core_load, rsp_valid, rsp_err, rsp_id, busy}), 128'(0));
      chk("mid_rst_ct", rsp_ct, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rr_m = 0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk); #1;
         if (rsp_valid || busy) bad = 1'b1;
      end
      chk("post_rst_ignore", 128'(bad), 128'(0));
      fill_pts();
      run_txn(4'b0100, 4, 0, 2, 1'b0);
      fill_pts();
      run_txn(4'b0011, 6, 1, predict(4'b0011), 1'b0);

      for (int t = 0; t < 40; t++) begin
         fill_pts();
         m = 4'($urandom_range(1, 15));
         r = $urandom_range(0, 9);
         lat = (r == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(1, 12);
         eid = predict(m);
         run_txn(m, lat, $urandom_range(0, 5), eid, (lat >= TO) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
